// File: rtl/alu_exec.sv
// ALU execute stage: 8-bit single-cycle operations with registered result strobes.
// Define ALU_MUL_EN to build the sequential shift-add multiplier for opcode 12; otherwise it is a NOP.
module alu_exec (
  input  logic       clk,
  input  logic       reset,
  input  logic       pause,
  input  logic       op_valid,
  input  logic [3:0] opcode,
  input  logic [7:0] operand,
  input  logic [7:0] accum_in,
  input  logic       cin,
  input  logic [7:0] dest_addr,
  input  logic       dest_mem,
  output logic [7:0] writeaddr,
  output logic [7:0] writedata,
  output logic       write_en,
  output logic       accum_write,
  output logic       zout,
  output logic       z_write,
  output logic       cout,
  output logic       c_write,
  output logic       stall
);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpAdc = 4'd1;
  localparam logic [3:0] OpSub = 4'd2;
  localparam logic [3:0] OpAnd = 4'd3;
  localparam logic [3:0] OpOr  = 4'd4;
  localparam logic [3:0] OpXor = 4'd5;
  localparam logic [3:0] OpNot = 4'd6;
  localparam logic [3:0] OpShl = 4'd7;
  localparam logic [3:0] OpShr = 4'd8;
  localparam logic [3:0] OpRlc = 4'd9;
  localparam logic [3:0] OpRrc = 4'd10;
  localparam logic [3:0] OpMov = 4'd11;
  localparam logic [3:0] OpMul = 4'd12;

  logic       accept;
  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_wr;
  logic       alu_cw;
  logic       mul_done;
  logic [7:0] mul_res;
  logic [7:0] mul_addr;
  logic       mul_c;
  logic       mul_mem;

  // Single-cycle datapath; alu_wr marks opcodes that produce strobes here.
  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    alu_wr  = 1'b1;
    alu_cw  = 1'b0;
    case (opcode)
      OpAdd: begin
        {alu_c, alu_res} = {1'b0, accum_in} + {1'b0, operand};
        alu_cw = 1'b1;
      end
      OpAdc: begin
        {alu_c, alu_res} = {1'b0, accum_in} + {1'b0, operand} + {8'h00, cin};
        alu_cw = 1'b1;
      end
      OpSub: begin
        alu_res = accum_in - operand;
        alu_c   = (accum_in >= operand);
        alu_cw  = 1'b1;
      end
      OpAnd: alu_res = accum_in & operand;
      OpOr:  alu_res = accum_in | operand;
      OpXor: alu_res = accum_in ^ operand;
      OpNot: alu_res = ~operand;
      OpShl: begin
        alu_res = {operand[6:0], 1'b0};
        alu_c   = operand[7];
        alu_cw  = 1'b1;
      end
      OpShr: begin
        alu_res = {1'b0, operand[7:1]};
        alu_c   = operand[0];
        alu_cw  = 1'b1;
      end
      OpRlc: begin
        alu_res = {operand[6:0], cin};
        alu_c   = operand[7];
        alu_cw  = 1'b1;
      end
      OpRrc: begin
        alu_res = {cin, operand[7:1]};
        alu_c   = operand[0];
        alu_cw  = 1'b1;
      end
      OpMov: alu_res = operand;
      // Multiply results come from the sequential unit, never from this path.
      OpMul: alu_wr = 1'b0;
      default: alu_wr = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {StIdle, StBusy, StDone} mul_state_e;

  mul_state_e  state_q;
  logic [2:0]  step_q;
  logic [15:0] prod_q;
  logic [15:0] mcand_q;
  logic [7:0]  mplier_q;
  logic [7:0]  addr_q;
  logic        mem_q;

  assign stall    = (state_q != StIdle);
  assign accept   = op_valid && !stall && !pause;
  assign mul_done = (state_q == StDone);
  assign mul_res  = prod_q[7:0];
  assign mul_c    = |prod_q[15:8];
  assign mul_addr = addr_q;
  assign mul_mem  = mem_q;

  // Operands are captured at acceptance; pause freezes every step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      step_q   <= 3'd0;
      prod_q   <= 16'h0000;
      mcand_q  <= 16'h0000;
      mplier_q <= 8'h00;
      addr_q   <= 8'h00;
      mem_q    <= 1'b0;
    end else if (!pause) begin
      case (state_q)
        StIdle: begin
          if (accept && (opcode == OpMul)) begin
            state_q  <= StBusy;
            step_q   <= 3'd0;
            prod_q   <= 16'h0000;
            mcand_q  <= {8'h00, accum_in};
            mplier_q <= operand;
            addr_q   <= dest_addr;
            mem_q    <= dest_mem;
          end
        end
        StBusy: begin
          if (mplier_q[0]) begin
            prod_q <= prod_q + mcand_q;
          end
          mcand_q  <= {mcand_q[14:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[7:1]};
          step_q   <= step_q + 3'd1;
          if (step_q == 3'd7) begin
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end
`else
  assign stall    = 1'b0;
  assign accept   = op_valid && !pause;
  assign mul_done = 1'b0;
  assign mul_res  = 8'h00;
  assign mul_c    = 1'b0;
  assign mul_addr = 8'h00;
  assign mul_mem  = 1'b0;
`endif

  // Result registers: data fields hold between ops, strobes last one unpaused cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      writeaddr   <= 8'h00;
      writedata   <= 8'h00;
      write_en    <= 1'b0;
      accum_write <= 1'b0;
      zout        <= 1'b0;
      z_write     <= 1'b0;
      cout        <= 1'b0;
      c_write     <= 1'b0;
    end else if (!pause) begin
      if (mul_done) begin
        writeaddr   <= mul_addr;
        writedata   <= mul_res;
        write_en    <= mul_mem;
        accum_write <= !mul_mem;
        zout        <= (mul_res == 8'h00);
        z_write     <= 1'b1;
        cout        <= mul_c;
        c_write     <= 1'b1;
      end else if (accept && alu_wr) begin
        writeaddr   <= dest_addr;
        writedata   <= alu_res;
        write_en    <= dest_mem;
        accum_write <= !dest_mem;
        zout        <= (alu_res == 8'h00);
        z_write     <= 1'b1;
        cout        <= alu_c;
        c_write     <= alu_cw;
      end else begin
        write_en    <= 1'b0;
        accum_write <= 1'b0;
        z_write     <= 1'b0;
        c_write     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed vectors, randomized ops against an arithmetic model.
// Multiplier checks are built when ALU_MUL_EN is defined, opcode-12-as-NOP checks otherwise.
module tb_alu_exec;

  logic       clk = 1'b0;
  logic       reset, pause, op_valid, cin, dest_mem;
  logic [3:0] opcode;
  logic [7:0] operand, accum_in, dest_addr;
  logic [7:0] writeaddr, writedata;
  logic       write_en, accum_write, zout, z_write, cout, c_write, stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec dut (
    .clk        (clk),
    .reset      (reset),
    .pause      (pause),
    .op_valid   (op_valid),
    .opcode     (opcode),
    .operand    (operand),
    .accum_in   (accum_in),
    .cin        (cin),
    .dest_addr  (dest_addr),
    .dest_mem   (dest_mem),
    .writeaddr  (writeaddr),
    .writedata  (writedata),
    .write_en   (write_en),
    .accum_write(accum_write),
    .zout       (zout),
    .z_write    (z_write),
    .cout       (cout),
    .c_write    (c_write),
    .stall      (stall)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input int a, input int b, input int c, input int m,
                       input int ad, input int v, input int p);
    opcode   = op[3:0];
    accum_in = a[7:0];
    operand  = b[7:0];
    cin      = c[0];
    dest_mem = m[0];
    dest_addr = ad[7:0];
    op_valid = v[0];
    pause    = p[0];
  endtask

  task automatic do_op(input int op, input int a, input int b, input int c, input int m,
                       input int ad);
    drive(op, a, b, c, m, ad, 1, 0);
    tick();
  endtask

  // Reference model from the opcode definitions using plain integer arithmetic.
  function automatic void model(input int op, input int a, input int b, input int c,
                                output int res, output int cy, output int zw, output int cw);
    int t;
    res = 0; cy = 0; zw = 1; cw = 1;
    case (op)
      0:  begin t = a + b;     res = t % 256; cy = (t > 255) ? 1 : 0; end
      1:  begin t = a + b + c; res = t % 256; cy = (t > 255) ? 1 : 0; end
      2:  begin res = (a - b + 256) % 256; cy = (a >= b) ? 1 : 0; end
      3:  begin res = a & b; cw = 0; end
      4:  begin res = a | b; cw = 0; end
      5:  begin res = a ^ b; cw = 0; end
      6:  begin res = 255 - b; cw = 0; end
      7:  begin res = (b * 2) % 256;     cy = (b >= 128) ? 1 : 0; end
      8:  begin res = b / 2;             cy = b % 2; end
      9:  begin res = (b * 2) % 256 + c; cy = (b >= 128) ? 1 : 0; end
      10: begin res = b / 2 + 128 * c;   cy = b % 2; end
      11: begin res = b; cw = 0; end
`ifdef ALU_MUL_EN
      12: begin t = a * b; res = t % 256; cy = (t > 255) ? 1 : 0; end
`endif
      default: begin zw = 0; cw = 0; end
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int res, cy, zw, cw, n, op, a, b, c, m, ad, v, p;
    int pv_strb, pv_res, pv_zw, ps, pl;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("rst_strobes", int'({write_en, accum_write, z_write, c_write}), 0);
    chk("rst_data", int'({writeaddr, writedata}), 0);
    chk("rst_flags", int'({zout, cout, stall}), 0);

    // An op offered while reset is low must not register.
    drive(0, 'hF0, 'h20, 0, 0, 0, 1, 0);
    tick();
    chk("rst_hold", int'({write_en, accum_write, z_write, c_write, writedata}), 0);

    // Release and accept on the first rising edge.
    reset = 1'b1;
    drive(0, 'hF0, 'h20, 0, 0, 'h33, 1, 0);
    tick();
    chk("add_wd", int'(writedata), 'h10);
    chk("add_aw", int'({accum_write, write_en}), 'b10);
    chk("add_flags", int'({cout, zout, c_write, z_write}), 'b1011);

    do_op(2, 'h05, 'h05, 0, 1, 'h12);
    chk("sub_we", int'({write_en, accum_write}), 'b10);
    chk("sub_addr", int'(writeaddr), 'h12);
    chk("sub_wd", int'(writedata), 0);
    chk("sub_flags", int'({zout, cout}), 'b11);

    do_op(10, 'h00, 'h01, 1, 0, 0);
    chk("rrc_wd", int'(writedata), 'h80);
    chk("rrc_c", int'(cout), 1);

    do_op(3, 'h0F, 'hF0, 0, 0, 0);
    chk("and_z", int'({zout, z_write}), 'b11);
    chk("and_cw", int'(c_write), 0);

    do_op(14, 'h12, 'h34, 1, 1, 'h56);
    chk("nop_strobes", int'({write_en, accum_write, z_write, c_write}), 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("idle_strobes", int'({write_en, accum_write, z_write, c_write}), 0);

    // Random single-cycle ops with occasional idle and pause cycles.
    pv_strb = 0; pv_res = 0; pv_zw = 0;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 15);
`ifdef ALU_MUL_EN
      if (op == 12) op = 13;
`endif
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      c  = $urandom_range(0, 1);
      m  = $urandom_range(0, 1);
      ad = $urandom_range(0, 255);
      v  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      p  = ($urandom_range(0, 5) == 0) ? 1 : 0;
      drive(op, a, b, c, m, ad, v, p);
      tick();
      if (p == 1) begin
        chk($sformatf("r%0d_pause_strb", i),
            int'({write_en, accum_write, z_write, c_write}), pv_strb);
        if (pv_zw == 1) chk($sformatf("r%0d_pause_wd", i), int'(writedata), pv_res);
      end else if (v == 1) begin
        model(op, a, b, c, res, cy, zw, cw);
        pv_strb = (zw == 1) ? ((m == 1) ? 'b1010 : 'b0110) : 0;
        if (cw == 1) pv_strb = pv_strb | 1;
        pv_res = res;
        pv_zw  = zw;
        chk($sformatf("r%0d_op%0d_strb", i, op),
            int'({write_en, accum_write, z_write, c_write}), pv_strb);
        if (zw == 1) begin
          chk($sformatf("r%0d_op%0d_wd", i, op), int'(writedata), res);
          chk($sformatf("r%0d_op%0d_z", i, op), int'(zout), (res == 0) ? 1 : 0);
          chk($sformatf("r%0d_op%0d_addr", i, op), int'(writeaddr), ad);
        end
        if (cw == 1) chk($sformatf("r%0d_op%0d_c", i, op), int'(cout), cy);
      end else begin
        pv_strb = 0;
        pv_zw   = 0;
        chk($sformatf("r%0d_idle_strb", i),
            int'({write_en, accum_write, z_write, c_write}), 0);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

`ifdef ALU_MUL_EN
    do_op(12, 'h13, 'h11, 0, 0, 'h40);
    chk("mul_stall_on", int'(stall), 1);
    // Operands change and an ADD waits; neither may disturb the multiply.
    drive(0, 'hFF, 'hFF, 0, 1, 'h55, 1, 0);
    n = 0;
    while (stall && n < 20) begin
      chk($sformatf("mul_busy%0d_strb", n), int'({write_en, accum_write, z_write, c_write}), 0);
      tick();
      n++;
    end
    chk("mul_stall_cycles", n, 9);
    chk("mul_wd", int'(writedata), 'h43);
    chk("mul_flags", int'({cout, zout, c_write, z_write}), 'b1011);
    chk("mul_dest", int'({accum_write, write_en, writeaddr}), 'h240);
    tick();
    chk("b2b_add_wd", int'(writedata), 'hFE);
    chk("b2b_add_dest", int'({write_en, cout, writeaddr}), 'h355);

    // Pause windows inside BUSY delay the result by exactly their length.
    for (int k = 0; k < 4; k++) begin
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      m  = $urandom_range(0, 1);
      ps = (k == 0) ? 3 : $urandom_range(1, 5);
      pl = (k == 0) ? 3 : $urandom_range(1, 3);
      do_op(12, a, b, 0, m, 'h20 + k);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      n = 0;
      while (stall && n < 30) begin
        pause = (n >= ps && n < ps + pl) ? 1'b1 : 1'b0;
        tick();
        n++;
      end
      pause = 1'b0;
      model(12, a, b, 0, res, cy, zw, cw);
      chk($sformatf("mulp%0d_cycles", k), n, 9 + pl);
      chk($sformatf("mulp%0d_wd", k), int'(writedata), res);
      chk($sformatf("mulp%0d_c", k), int'(cout), cy);
      chk($sformatf("mulp%0d_we", k), int'({write_en, accum_write}), (m == 1) ? 'b10 : 'b01);
    end
    tick();

    // Reset mid-multiply aborts it.
    do_op(12, 'h13, 'h11, 0, 1, 'h77);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("abort_busy", int'(stall), 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_outputs", int'({write_en, accum_write, z_write, c_write, zout, cout, stall}), 0);
    chk("abort_data", int'({writeaddr, writedata}), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("abort_post%0d", k),
          int'({write_en, accum_write, z_write, c_write, stall}), 0);
    end
`else
    do_op(12, 'h13, 'h11, 0, 0, 'h40);
    chk("op12_nop_strb", int'({write_en, accum_write, z_write, c_write}), 0);
    chk("op12_nop_stall", int'(stall), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("op12_post%0d", k), int'({write_en, accum_write, z_write, c_write, stall}), 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
